// File: rtl/cnt_obi_pkg.sv
// Shared OBI request/response types used by the counter register block
// and by any initiator or responder that talks to it.
package cnt_obi_pkg;

    localparam int unsigned ObiAddrWidth = 32'd32;
    localparam int unsigned ObiDataWidth = 32'd32;
    localparam int unsigned ObiBeWidth   = 32'd4;

    // OBI A-channel driven by the manager.
    typedef struct packed {
        logic                      req;
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiBeWidth-1:0]     be;
        logic [ObiDataWidth-1:0]   wdata;
    } obi_req_t;

    // OBI grant plus R-channel driven by the responder.
    typedef struct packed {
        logic                      gnt;
        logic                      rvalid;
        logic [ObiDataWidth-1:0]   rdata;
    } obi_resp_t;

    // Pack the individual A-channel fields into a request struct.
    function automatic obi_req_t obi_req_build(
        input logic                    req,
        input logic [ObiAddrWidth-1:0] addr,
        input logic                    we,
        input logic [ObiBeWidth-1:0]   be,
        input logic [ObiDataWidth-1:0] wdata
    );
        obi_req_t r;
        r.req   = req;
        r.addr  = addr;
        r.we    = we;
        r.be    = be;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/cnt_obi_initiator.sv
// Single-outstanding OBI manager: takes one command over valid/ready,
// runs it on OBI, returns read data or a timeout error over valid/ready.
// A timed-out transaction leaves a drain flag so its late rvalid is
// swallowed before the next command is accepted.
module cnt_obi_initiator
    import cnt_obi_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 32'd64,
    parameter int unsigned AddrWidth     = 32'd32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_we_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [31:0]          cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output obi_req_t             obi_req_o,
    input  obi_resp_t            obi_rsp_i,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RESP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [3:0]           be;
        logic [31:0]          wdata;
    } cmd_t;

    // With TimeoutCycles = 0 the counter collapses to one idle bit.
    localparam bit          TimeoutEn = (TimeoutCycles != 32'd0);
    localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TimeoutCycles + 32'd1) : 32'd1;
    localparam logic [CntWidth-1:0] CntLast = TimeoutEn ? CntWidth'(TimeoutCycles - 32'd1) : '0;
    localparam logic [CntWidth-1:0] CntSat  = TimeoutEn ? CntWidth'(TimeoutCycles) : '0;
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(32'd1);

    state_e              state_r, state_s;
    cmd_t                cmd_r, cmd_s;
    logic                req_r, req_s;
    logic [CntWidth-1:0] cnt_r, cnt_s;
    logic                drain_r, drain_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [31:0]         rsp_rdata_r, rsp_rdata_s;
    logic                rsp_err_r, rsp_err_s;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cmd_s       = cmd_r;
        req_s       = req_r;
        cnt_s       = cnt_r;
        drain_s     = drain_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_s     = ST_ADDR;
                    cmd_s.addr  = cmd_addr_i;
                    cmd_s.we    = cmd_we_i;
                    cmd_s.be    = cmd_be_i;
                    cmd_s.wdata = cmd_wdata_i;
                    req_s       = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // Request stays up with stable fields until granted.
                if (obi_rsp_i.gnt) begin
                    state_s = ST_RESP;
                    req_s   = 1'b0;
                    cnt_s   = '0;
                end else begin
                    req_s = 1'b1;
                end
            end
            ST_RESP: begin
                // rvalid takes priority over expiry in the same cycle.
                if (obi_rsp_i.rvalid) begin
                    state_s     = ST_DONE;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = cmd_r.we ? 32'h0000_0000 : obi_rsp_i.rdata;
                    rsp_err_s   = 1'b0;
                end else if (TimeoutEn && (cnt_r == CntLast)) begin
                    state_s     = ST_DONE;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = 32'h0000_0000;
                    rsp_err_s   = 1'b1;
                    drain_s     = 1'b1;
                end else begin
                    cnt_s = (cnt_r == CntSat) ? cnt_r : (cnt_r + CntOne);
                end
            end
            ST_DONE: begin
                // A late rvalid arriving while the response is held is
                // already the one the drain flag is waiting for.
                drain_s = drain_r && !obi_rsp_i.rvalid;
                if (rsp_ready_i) begin
                    state_s     = drain_s ? ST_DRAIN : ST_IDLE;
                    rsp_valid_s = 1'b0;
                    rsp_rdata_s = 32'h0000_0000;
                    rsp_err_s   = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (obi_rsp_i.rvalid) begin
                    state_s = ST_IDLE;
                    drain_s = 1'b0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                req_s       = 1'b0;
                drain_s     = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            cmd_r       <= '0;
            req_r       <= 1'b0;
            cnt_r       <= '0;
            drain_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_r       <= cmd_s;
            req_r       <= req_s;
            cnt_r       <= cnt_s;
            drain_r     <= drain_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign obi_req_o   = obi_req_build(req_r, ObiAddrWidth'(cmd_r.addr), cmd_r.we,
                                       cmd_r.be, cmd_r.wdata);
    assign cmd_ready_o = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_cnt_obi_initiator.sv
// Directed bench for cnt_obi_initiator with an inline OBI responder and
// a response scoreboard; TimeoutCycles is set to 4.
module tb_cnt_obi_initiator;
    import cnt_obi_pkg::*;

    localparam int unsigned Tmo = 32'd4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    obi_req_t    obi_req;
    obi_resp_t   obi_rsp;
    logic        busy;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cnt_obi_initiator #(
        .TimeoutCycles (Tmo),
        .AddrWidth     (32'd32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_we_i    (cmd_we),
        .cmd_be_i    (cmd_be),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .obi_req_o   (obi_req),
        .obi_rsp_i   (obi_rsp),
        .busy_o      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected response and compare with the DUT outputs.
    task automatic sb_check(output exp_t e);
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end else begin
            e = '0;
        end
    endtask

    task automatic drive_cmd(input logic [31:0] addr, input logic we, input logic [3:0] be,
                             input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_we    = we;
        cmd_be    = be;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = ~addr;
        cmd_we    = ~we;
        cmd_be    = ~be;
        cmd_wdata = ~wdata;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Full transaction: gnt after gnt_wait stalls, rvalid after rv_wait
    // RESP cycles, consumer ready after rdy_wait DONE cycles.
    task automatic txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input int gnt_wait, input int rv_wait,
                       input logic [31:0] rdata, input int rdy_wait);
        exp_t e;
        exp_t got;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        e.err   = 1'b0;
        e.rdata = we ? 32'h0000_0000 : rdata;
        sb_q.push_back(e);
        drive_cmd(addr, we, be, wdata);
        for (int c = 0; c <= gnt_wait; c++) begin
            chk("addr_req", 64'(obi_req.req), 64'd1);
            chk("addr_addr", 64'(obi_req.addr), 64'(addr));
            chk("addr_we", 64'(obi_req.we), 64'(we));
            chk("addr_be", 64'(obi_req.be), 64'(be));
            chk("addr_wdata", 64'(obi_req.wdata), 64'(wdata));
            chk("addr_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("addr_busy", 64'(busy), 64'd1);
            obi_rsp.gnt = (c == gnt_wait);
            tick();
        end
        obi_rsp.gnt = 1'b0;
        for (int c = 0; c <= rv_wait; c++) begin
            chk("resp_req", 64'(obi_req.req), 64'd0);
            chk("resp_valid", 64'(rsp_valid), 64'd0);
            obi_rsp.rvalid = (c == rv_wait);
            obi_rsp.rdata  = (c == rv_wait) ? rdata : 32'h5A5A_5A5A;
            tick();
        end
        obi_rsp.rvalid = 1'b0;
        obi_rsp.rdata  = 32'h0000_0000;
        chk("done_valid", 64'(rsp_valid), 64'd1);
        sb_check(got);
        for (int c = 0; c < rdy_wait; c++) begin
            rsp_ready = 1'b0;
            tick();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("hold_err", 64'(rsp_err), 64'd0);
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_req", 64'(obi_req.req), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_valid", 64'(rsp_valid), 64'd0);
        chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        exp_t e;
        exp_t got;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0000_0000;
        cmd_we    = 1'b0;
        cmd_be    = 4'h0;
        cmd_wdata = 32'h0000_0000;
        rsp_ready = 1'b0;
        obi_rsp   = '0;

        // Reset state
        do_reset();
        chk("rst_req", 64'(obi_req), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        // Stray responder/consumer activity in IDLE is ignored
        obi_rsp.gnt    = 1'b1;
        obi_rsp.rvalid = 1'b1;
        obi_rsp.rdata  = 32'hFFFF_0000;
        rsp_ready      = 1'b1;
        tick();
        obi_rsp   = '0;
        rsp_ready = 1'b0;
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_valid", 64'(rsp_valid), 64'd0);
        chk("stray_req", 64'(obi_req.req), 64'd0);

        // Write, zero-wait responder; read data must be forced to 0
        txn(32'h0000_0004, 1'b1, 4'hF, 32'h0000_0100, 0, 0, 32'hFFFF_FFFF, 0);
        // Read with a 5-cycle grant stall
        txn(32'h0000_0010, 1'b0, 4'hF, 32'h0000_0000, 5, 0, 32'hDEAD_BEEF, 0);
        // Read with 10 cycles of response backpressure
        txn(32'h0000_0014, 1'b0, 4'h3, 32'h1111_2222, 0, 1, 32'hCAFE_F00D, 10);
        // Expiry race: rvalid on the last allowed RESP cycle wins
        txn(32'h0000_0018, 1'b0, 4'hF, 32'h0000_0000, 0, 3, 32'h0BAD_CAFE, 0);

        // Timeout: granted, rvalid 20 cycles after RESP entry
        e.err   = 1'b1;
        e.rdata = 32'h0000_0000;
        sb_q.push_back(e);
        drive_cmd(32'h0000_000C, 1'b0, 4'hF, 32'h0000_0000);
        chk("tmo_req", 64'(obi_req.req), 64'd1);
        obi_rsp.gnt = 1'b1;
        tick();
        obi_rsp.gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("tmo_wait_valid", 64'(rsp_valid), 64'd0);
            tick();
        end
        chk("tmo_valid", 64'(rsp_valid), 64'd1);
        sb_check(got);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int c = 5; c < 20; c++) begin
            chk("drain_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_valid", 64'(rsp_valid), 64'd0);
            chk("drain_req", 64'(obi_req.req), 64'd0);
            tick();
        end
        obi_rsp.rvalid = 1'b1;
        obi_rsp.rdata  = 32'hBAD0_BAD0;
        tick();
        obi_rsp = '0;
        chk("drained_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("drained_busy", 64'(busy), 64'd0);
        chk("drained_valid", 64'(rsp_valid), 64'd0);
        // Follow-up read after the drain
        txn(32'h0000_0008, 1'b0, 4'hF, 32'h0000_0000, 0, 0, 32'h1357_9BDF, 0);

        // Reset while in ADDR
        drive_cmd(32'h0000_0020, 1'b1, 4'hF, 32'hAAAA_5555);
        chk("rsta_req_before", 64'(obi_req.req), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rsta_req", 64'(obi_req.req), 64'd0);
        chk("rsta_valid", 64'(rsp_valid), 64'd0);
        chk("rsta_cmd_ready", 64'(cmd_ready), 64'd1);
        txn(32'h0000_0024, 1'b0, 4'hF, 32'h0000_0000, 1, 0, 32'h2468_ACE0, 0);

        // Reset while in DONE
        drive_cmd(32'h0000_0028, 1'b0, 4'hF, 32'h0000_0000);
        obi_rsp.gnt = 1'b1;
        tick();
        obi_rsp.gnt    = 1'b0;
        obi_rsp.rvalid = 1'b1;
        obi_rsp.rdata  = 32'h7777_8888;
        tick();
        obi_rsp = '0;
        chk("rstd_valid_before", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstd_valid", 64'(rsp_valid), 64'd0);
        chk("rstd_rdata", 64'(rsp_rdata), 64'd0);
        chk("rstd_req", 64'(obi_req.req), 64'd0);
        chk("rstd_cmd_ready", 64'(cmd_ready), 64'd1);
        txn(32'h0000_002C, 1'b1, 4'h5, 32'h0102_0304, 0, 0, 32'h9999_9999, 2);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
